decoder_scan_ctrl: RTL and testbench

Scan sequencer that sits directly upstream of the 4-to-16 line decoder. It generates the decoder's 4-bit address and enable to walk a selectable subset of 16 lines, such as LED-matrix rows or keypad rows. It holds each line for a programmable dwell and inserts blanking between lines so the enable is never high while the address changes. It samples a 1-bit sense return per line and publishes a 16-bit result once per sweep.

---
 rtl/decoder_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer feeding a 4-to-16 line decoder: walks the masked channels with a
// dwell/blank cadence, samples a sense return per channel and publishes one result per sweep.
module decoder_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int BLANK = 2,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic [15:0] mask,
  input  logic        sense,
  output logic [3:0]  addr,
  output logic        dec_en,
  output logic        busy,
  output logic        sweep_done,
  output logic [15:0] scan_data
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_BLANK} state_e;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

  state_e            state_q, state_d;
  logic [3:0]        addr_q, addr_d;
  logic              dec_en_q, dec_en_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;
  logic [15:0]       scan_data_q, scan_data_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [15:0]       mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       higher;

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Masked channels strictly above the current address; empty means end of sweep.
  assign higher = mask_q & ~((16'd2 << addr_q) - 16'd1);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sweep_done_d = 1'b0;
    scan_data_d  = scan_data_q;
    shadow_d     = shadow_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && (mask != 16'd0)) begin
          mask_d   = mask;
          shadow_d = '0;
          addr_d   = lowest_set(mask);
          cnt_d    = '0;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (stop) begin
          state_d  = S_IDLE;
          shadow_d = '0;
          cnt_d    = '0;
        end else if (cnt_q == DWELL_LAST) begin
          shadow_d[addr_q] = sense;
          cnt_d            = '0;
          state_d          = S_BLANK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BLANK: begin
        if ((cnt_q == BLANK_LAST) && (higher == 16'd0)) begin
          // End of sweep completes even under stop; stop only blocks the restart.
          sweep_done_d = 1'b1;
          scan_data_d  = shadow_q;
          cnt_d        = '0;
          if (continuous && !stop && (mask != 16'd0)) begin
            mask_d   = mask;
            shadow_d = '0;
            addr_d   = lowest_set(mask);
            state_d  = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (stop) begin
          state_d  = S_IDLE;
          shadow_d = '0;
          cnt_d    = '0;
        end else if (cnt_q == BLANK_LAST) begin
          addr_d  = lowest_set(higher);
          cnt_d   = '0;
          state_d = S_DRIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    dec_en_d = (state_d == S_DRIVE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      dec_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      scan_data_q  <= '0;
      shadow_q     <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      dec_en_q     <= dec_en_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      scan_data_q  <= scan_data_d;
      shadow_q     <= shadow_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
    end
  end

  assign addr       = addr_q;
  assign dec_en     = dec_en_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign scan_data  = scan_data_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: reset, full/sparse sweeps, abort, continuous mode
// and ignored requests, all against hand-computed cycle counts and results.
module tb_decoder_scan_ctrl;

  localparam int DWELL = 4;
  localparam int BLANK = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [15:0] mask;
  logic        sense;
  logic [3:0]  addr;
  logic        dec_en;
  logic        busy;
  logic        sweep_done;
  logic [15:0] scan_data;

  int          sense_mode;
  int          n_checks;
  int          n_pass;
  logic [31:0] exp_q[$];

  decoder_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .mask       (mask),
    .sense      (sense),
    .addr       (addr),
    .dec_en     (dec_en),
    .busy       (busy),
    .sweep_done (sweep_done),
    .scan_data  (scan_data)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sense return emulates a single active line on the addressed channel.
  always_comb begin
    case (sense_mode)
      0:       sense = (addr == 4'd5);
      1:       sense = 1'b1;
      default: sense = (addr == 4'd2);
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Follows one sweep cycle by cycle, checking dwell/blank lengths, channel order
  // (from exp_q) and address stability while the decoder is enabled.
  task automatic run_sweep(input int max_ticks, input logic init_en, input int pulse_at,
                           output int done_at, output logic [15:0] d_data,
                           output logic d_busy, output logic d_en, output logic [3:0] d_addr);
    logic        prev_en;
    logic [3:0]  prev_addr;
    int          hi;
    int          lo;
    logic [31:0] exp_a;
    prev_en   = init_en;
    prev_addr = addr;
    hi        = init_en ? 1 : 0;
    lo        = -1;
    done_at   = -1;
    d_data    = '0;
    d_busy    = 1'b0;
    d_en      = 1'b0;
    d_addr    = '0;
    for (int t = 1; t <= max_ticks; t++) begin
      tick();
      start = (t == pulse_at);
      if (sweep_done) begin
        done_at = t;
        d_data  = scan_data;
        d_busy  = busy;
        d_en    = dec_en;
        d_addr  = addr;
        check_eq("last_blank", lo, BLANK);
        break;
      end
      if (dec_en && !prev_en) begin
        if (lo >= 0) check_eq("blank_len", lo, BLANK);
        exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check_eq("chan_addr", addr, exp_a);
        hi = 1;
      end else if (dec_en) begin
        check_eq("addr_stable", addr, prev_addr);
        hi++;
      end else if (prev_en) begin
        check_eq("dwell_len", hi, DWELL);
        lo = 1;
      end else begin
        lo++;
      end
      prev_en   = dec_en;
      prev_addr = addr;
    end
    check_eq("sweep_done_seen", done_at >= 0, 1);
    check_eq("chans_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  int          done_at;
  logic [15:0] d_data;
  logic        d_busy;
  logic        d_en;
  logic [3:0]  d_addr;
  logic        seen;
  logic        found;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    mask       = 16'h0000;
    sense_mode = 0;
    repeat (3) tick();
    check_eq("rst_addr", addr, 0);
    check_eq("rst_dec_en", dec_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sweep_done", sweep_done, 0);
    check_eq("rst_scan_data", scan_data, 16'h0000);
    rst_n = 1'b1;
    tick();

    // start with empty mask is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("mask0_busy", busy, 0);
    check_eq("mask0_dec_en", dec_en, 0);

    // start together with stop is ignored
    mask  = 16'h000F;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    check_eq("startstop_busy", busy, 0);
    check_eq("startstop_dec_en", dec_en, 0);

    // full sweep, sense only on channel 5
    mask  = 16'hFFFF;
    start = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    run_sweep(120, 1'b0, -1, done_at, d_data, d_busy, d_en, d_addr);
    check_eq("full_done_at", done_at, 97);
    check_eq("full_scan_data", d_data, 16'h0020);
    check_eq("full_busy_at_done", d_busy, 0);
    check_eq("full_dec_en_at_done", d_en, 0);

    // abort while channel 7 is driven
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (dec_en && addr == 4'd7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("abort_reach_ch7", found, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("abort_dec_en", dec_en, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_sweep_done", sweep_done, 0);
    check_eq("abort_addr_hold", addr, 7);
    check_eq("abort_scan_data", scan_data, 16'h0020);
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (sweep_done || busy) seen = 1'b1;
    end
    check_eq("abort_quiet", seen, 0);
    check_eq("abort_scan_hold", scan_data, 16'h0020);

    // sparse mask, with a start pulse mid-sweep that must be ignored
    sense_mode = 1;
    mask       = 16'h8001;
    start      = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(15);
    run_sweep(40, 1'b0, 5, done_at, d_data, d_busy, d_en, d_addr);
    check_eq("sparse_done_at", done_at, 13);
    check_eq("sparse_scan_data", d_data, 16'h8001);
    check_eq("sparse_busy_at_done", d_busy, 0);
    tick();

    // continuous mode, mask cleared during second sweep ends the run
    sense_mode = 2;
    mask       = 16'h000F;
    continuous = 1'b1;
    start      = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    run_sweep(60, 1'b0, -1, done_at, d_data, d_busy, d_en, d_addr);
    check_eq("cont1_done_at", done_at, 25);
    check_eq("cont1_scan_data", d_data, 16'h0004);
    check_eq("cont1_dec_en", d_en, 1);
    check_eq("cont1_addr", d_addr, 0);
    check_eq("cont1_busy", d_busy, 1);
    mask = 16'h0000;
    for (int i = 1; i < 4; i++) exp_q.push_back(i);
    run_sweep(60, 1'b1, -1, done_at, d_data, d_busy, d_en, d_addr);
    check_eq("cont2_done_at", done_at, 24);
    check_eq("cont2_scan_data", d_data, 16'h0004);
    check_eq("cont2_dec_en", d_en, 0);
    check_eq("cont2_busy", d_busy, 0);
    tick();
    check_eq("cont_end_busy", busy, 0);
    check_eq("cont_end_pulse", sweep_done, 0);
    continuous = 1'b0;

    // reset in the middle of a sweep
    sense_mode = 0;
    mask       = 16'hFFFF;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    check_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("mid_rst_addr", addr, 0);
    check_eq("mid_rst_dec_en", dec_en, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_sweep_done", sweep_done, 0);
    check_eq("mid_rst_scan_data", scan_data, 16'h0000);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int t = 0; t < 120; t++) begin
      tick();
      if (sweep_done || busy) seen = 1'b1;
    end
    check_eq("post_rst_quiet", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
